// File: rtl/ble_pkg.sv
// rtl/ble_pkg.sv - shared BLE link-layer constants, FSM state type and whitening seed helper
package ble_pkg;

    localparam int PREAMBLE_AA_BITS = 40;
    localparam int HDR_BITS         = 16;
    localparam int CRC_BITS         = 24;

    // x^7 + x^4 + 1: feedback lands on register bits 4 and 0 after the shift.
    localparam logic [6:0] LFSR_POLY = 7'h11;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        PAYLOAD,
        CRC
    } ble_state_e;

    // Register bit 6 is the first whitening bit out. Bit 0 is forced to 1, and
    // bits 6..1 carry channel bits 0..5, so channel bit 0 whitens the first PDU bit.
    function automatic logic [6:0] whiten_seed(input logic [5:0] ch);
        return {ch[0], ch[1], ch[2], ch[3], ch[4], ch[5], 1'b1};
    endfunction

endpackage

// File: rtl/scramble_core.sv
// rtl/scramble_core.sv - BLE whitening LFSR, channel seeded, one bit per advance
//
// Ports:
//   clk, rst     clock, synchronous active-high reset (reseeds as channel 0)
//   load         reseed from channel (wins over advance)
//   channel      6-bit channel index used as seed
//   advance      step the LFSR by one bit
//   whiten_bit   current whitening bit to XOR with the on-air bit
module scramble_core (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [5:0] channel,
    input  logic       advance,
    output logic       whiten_bit
);
    import ble_pkg::*;

    logic [6:0] lfsr;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= whiten_seed(6'd0);
        end else if (load) begin
            lfsr <= whiten_seed(channel);
        end else if (advance) begin
            lfsr <= {lfsr[5:0], 1'b0} ^ (lfsr[6] ? LFSR_POLY : 7'h00);
        end
    end

    assign whiten_bit = lfsr[6];

endmodule

// File: rtl/descramble_rx.sv
// rtl/descramble_rx.sv - BLE receive de-whitening with length extraction and end-of-packet marking
//
// Build option: DESCRAMBLE_LEN_CHECK_EN enables aborting packets whose length byte
// exceeds MAX_PDU_LEN; without it length_error stays 0 and every length is accepted.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   channel_number        channel index, latched on channel_number_load while idle
//   channel_number_load   latch request (ignored while busy)
//   access_address_hit    start of packet; next valid bit is header bit 0
//   data_in/_valid        whitened on-air bit stream, LSB first
//   data_out/_valid       de-whitened bit stream, one cycle latency
//   data_out_valid_last   marks the final CRC bit
//   pdu_length/_valid     length byte from the header and its update pulse
//   length_error          abort pulse for an oversize length
//   busy                  packet in progress
module descramble_rx #(
    parameter int CHANNEL_NUMBER_BIT_WIDTH = 6,
    parameter int MAX_PDU_LEN              = 255
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] channel_number,
    input  logic                                channel_number_load,
    input  logic                                access_address_hit,
    input  logic                                data_in,
    input  logic                                data_in_valid,
    output logic                                data_out,
    output logic                                data_out_valid,
    output logic                                data_out_valid_last,
    output logic [7:0]                          pdu_length,
    output logic                                pdu_length_valid,
    output logic                                length_error,
    output logic                                busy
);
    import ble_pkg::*;

`ifdef DESCRAMBLE_LEN_CHECK_EN
    localparam bit LEN_CHECK = 1'b1;
`else
    localparam bit LEN_CHECK = 1'b0;
`endif

    localparam logic [8:0]  MAX_LEN      = 9'(MAX_PDU_LEN);
    localparam logic [11:0] HDR_LAST     = 12'(HDR_BITS - 1);
    localparam logic [11:0] PACKET_FIXED = 12'(HDR_BITS + CRC_BITS - 1);

    ble_state_e state;
    logic [11:0] bit_cnt;
    logic [7:0]  len_shift;
    logic [5:0]  ch_latched;

    logic [5:0]  ch_in;
    logic        load_accept;
    logic        advance;
    logic        whiten_bit;
    logic        dbit;
    logic [7:0]  len_next;
    logic        len_bad;
    logic [11:0] len_x8;
    logic [11:0] payload_last;
    logic [11:0] packet_last;

    assign ch_in       = 6'(channel_number);
    assign busy        = (state != IDLE);
    assign load_accept = channel_number_load && !busy;
    // A hit owns its cycle: a coincident valid bit belongs to no packet.
    assign advance     = data_in_valid && busy && !access_address_hit;
    assign dbit        = data_in ^ whiten_bit;

    // Header shifts in LSB first; after bit 15, bits 8..15 sit in len_shift.
    assign len_next     = {dbit, len_shift[7:1]};
    assign len_bad      = LEN_CHECK && ({1'b0, len_next} > MAX_LEN);
    assign len_x8       = {1'b0, pdu_length, 3'b000};
    assign payload_last = HDR_LAST + len_x8;
    assign packet_last  = PACKET_FIXED + len_x8;

    // Channel load reseeds straight away so the idle LFSR always reflects the
    // latched channel; a hit reseeds for the new packet.
    scramble_core u_scramble_core (
        .clk        (clk),
        .rst        (rst),
        .load       (load_accept || access_address_hit),
        .channel    (load_accept ? ch_in : ch_latched),
        .advance    (advance),
        .whiten_bit (whiten_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= IDLE;
            bit_cnt             <= 12'd0;
            len_shift           <= 8'd0;
            ch_latched          <= 6'd0;
            data_out            <= 1'b0;
            data_out_valid      <= 1'b0;
            data_out_valid_last <= 1'b0;
            pdu_length          <= 8'd0;
            pdu_length_valid    <= 1'b0;
            length_error        <= 1'b0;
        end else begin
            data_out_valid      <= 1'b0;
            data_out_valid_last <= 1'b0;
            pdu_length_valid    <= 1'b0;
            length_error        <= 1'b0;

            if (load_accept) begin
                ch_latched <= ch_in;
            end

            if (access_address_hit) begin
                // Restart drops any packet in flight silently.
                state   <= HEADER;
                bit_cnt <= 12'd0;
            end else if (advance) begin
                data_out       <= dbit;
                data_out_valid <= 1'b1;
                bit_cnt        <= bit_cnt + 12'd1;
                unique case (state)
                    HEADER: begin
                        len_shift <= len_next;
                        if (bit_cnt == HDR_LAST) begin
                            pdu_length       <= len_next;
                            pdu_length_valid <= 1'b1;
                            if (len_bad) begin
                                length_error <= 1'b1;
                                state        <= IDLE;
                            end else if (len_next == 8'd0) begin
                                state <= CRC;
                            end else begin
                                state <= PAYLOAD;
                            end
                        end
                    end
                    PAYLOAD: begin
                        if (bit_cnt == payload_last) begin
                            state <= CRC;
                        end
                    end
                    CRC: begin
                        if (bit_cnt == packet_last) begin
                            data_out_valid_last <= 1'b1;
                            state               <= IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
